// File: rtl/float_relu_grad_if.sv
// rtl/float_relu_grad_if.sv - forward, gradient and output stream bundle for float_relu_grad
interface float_relu_grad_if #(
  parameter int FW = 32,
  parameter int CW = 5
);
  logic          fwd_valid;
  logic          fwd_ready;
  logic [FW-1:0] fwd_in;
  logic          grad_valid;
  logic          grad_ready;
  logic [FW-1:0] grad_in;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] grad_out;
  logic [CW-1:0] mask_count;

  modport master (
    output fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
    input  fwd_ready, grad_ready, out_valid, grad_out, mask_count
  );

  modport slave (
    input  fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
    output fwd_ready, grad_ready, out_valid, grad_out, mask_count
  );
endinterface

// File: rtl/float_relu_grad.sv
// rtl/float_relu_grad.sv - ReLU backward gate: forward mask FIFO gating the gradient stream
// Optional leaky slope on masked-off gradients: define FLOAT_RELU_GRAD_LEAKY_EN.
module float_relu_grad #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int DEPTH      = 16,
  parameter int LEAK_SHIFT = 6
) (
  input  logic              clk,
  input  logic              rst,
  float_relu_grad_if.slave  bus
);
  localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LEAK_SHIFT < 1) begin : g_bad_params
      $error("float_relu_grad: DEPTH must be a power of two >= 2 and LEAK_SHIFT >= 1");
    end
  endgenerate

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [DEPTH-1:0] mask_mem;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            mask_bit;
  logic            pop_bit;
  logic [FW-1:0]   gated;
  logic [FW-1:0]   out_q;
  logic            out_v;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.fwd_ready  = !full;
  assign bus.grad_ready = !empty && (!out_v || bus.out_ready);
  assign bus.out_valid  = out_v;
  assign bus.grad_out   = out_q;
  assign bus.mask_count = wr_ptr - rd_ptr;

  assign push     = bus.fwd_valid && !full;
  assign pop      = bus.grad_valid && bus.grad_ready;
  assign mask_bit = !bus.fwd_in[FW-1] && (|bus.fwd_in[FW-2:0]);
  assign pop_bit  = mask_mem[rd_ptr[AW-1:0]];

`ifdef FLOAT_RELU_GRAD_LEAKY_EN
  logic [EXP_WIDTH-1:0] grad_exp;
  assign grad_exp = bus.grad_in[FW-2:MAN_WIDTH];

  always_comb begin
    gated = bus.grad_in;
    if (&grad_exp) begin
      gated = bus.grad_in;
    end else if (grad_exp <= EXP_WIDTH'(LEAK_SHIFT)) begin
      gated = {bus.grad_in[FW-1], {(FW-1){1'b0}}};
    end else begin
      gated = {bus.grad_in[FW-1], grad_exp - EXP_WIDTH'(LEAK_SHIFT), bus.grad_in[MAN_WIDTH-1:0]};
    end
  end
`else
  assign gated = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_v  <= 1'b0;
      out_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        out_q  <= pop_bit ? bus.grad_in : gated;
        out_v  <= 1'b1;
      end else if (out_v && bus.out_ready) begin
        out_v  <= 1'b0;
      end
    end
  end

  // Mask storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr[AW-1:0]] <= mask_bit;
    end
  end
endmodule
